muldiv_unit: RTL

//  Multi-cycle HI/LO multiply/divide unit in the EX stage for MULT/MULTU/DIV/DIVU/MTHI/MTLO.

---
 rtl/md_pkg.sv | 35 +++
 rtl/md_iter_step.sv | 44 ++++
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM
// state encoding, default operand width and an op-class helper.
package md_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } md_state_t;

  // True for the ops that run through the iterative datapath.
  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the ops that interpret operands as two's complement.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  // True for the divide ops.
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// One radix-2 iteration of the magnitude datapath.
// Multiply: acc = {partial_hi, multiplier}; add operand to the upper half when
//   the current multiplier bit is set, then shift the whole pair right.
// Divide: acc = {remainder, dividend/quotient}; shift left, try subtracting the
//   divisor from the widened remainder and restore on borrow.
module md_iter_step
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shifted;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] div_rem;

  // Compute both candidate next accumulators and select by mode.
  always_comb begin
    // Upper half plus multiplicand keeps its carry, which becomes the new MSB.
    mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);

    // Remainder shifted left with the next dividend bit; one extra bit so the
    // compare against a divisor up to 2^WIDTH-1 cannot overflow.
    div_shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge      = (div_shifted >= {1'b0, operand});
    // When the subtraction succeeds the true difference fits in WIDTH bits,
    // so modular WIDTH-bit arithmetic gives the exact result.
    div_diff    = div_shifted[WIDTH-1:0] - operand;
    div_rem     = div_ge ? div_diff : div_shifted[WIDTH-1:0];

    if (is_div) begin
      acc_next = {div_rem, acc[WIDTH-2:0], div_ge};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit in the EX stage. Handles
// MULT/MULTU/DIV/DIVU iteratively on magnitudes, applies signs in a final FIX
// cycle, and executes MTHI/MTLO in one cycle. Raises md_stall toward the
// hazard unit when an ID-stage HI/LO user would collide with an op in flight.
module muldiv_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             md_start_ex,
  input  logic [2:0]       md_op_ex,
  input  logic [WIDTH-1:0] src_a_ex,
  input  logic [WIDTH-1:0] src_b_ex,
  input  logic             md_use_id,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             md_busy,
  output logic             md_stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_t          state_reg, state_next;
  logic [CW-1:0]      count_reg, count_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   operand_reg, operand_next;
  logic               is_div_reg, is_div_next;
  logic               neg_res_reg, neg_res_next;
  logic               neg_rem_reg, neg_rem_next;
  logic               b_zero_reg, b_zero_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;

  logic [2*WIDTH-1:0] step_acc;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] fixed_prod;
  logic [WIDTH-1:0]   fixed_quot;
  logic [WIDTH-1:0]   fixed_rem;

  md_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div   (is_div_reg),
    .acc      (acc_reg),
    .operand  (operand_reg),
    .acc_next (step_acc)
  );

  // Operand magnitudes and sign-corrected results. Negating the most-negative
  // value wraps to 2^(WIDTH-1), which is exactly its magnitude as unsigned.
  always_comb begin
    a_neg      = is_signed_op(md_op_ex) & src_a_ex[WIDTH-1];
    b_neg      = is_signed_op(md_op_ex) & src_b_ex[WIDTH-1];
    a_mag      = a_neg ? (~src_a_ex + 1'b1) : src_a_ex;
    b_mag      = b_neg ? (~src_b_ex + 1'b1) : src_b_ex;
    fixed_prod = neg_res_reg ? (~acc_reg + 1'b1) : acc_reg;
    fixed_quot = neg_res_reg ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
    fixed_rem  = neg_rem_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1) : acc_reg[2*WIDTH-1:WIDTH];
  end

  // Next-state and datapath-load decisions for the IDLE/CALC/FIX sequence.
  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    acc_next     = acc_reg;
    operand_next = operand_reg;
    is_div_next  = is_div_reg;
    neg_res_next = neg_res_reg;
    neg_rem_next = neg_rem_reg;
    b_zero_next  = b_zero_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;

    case (state_reg)
      S_IDLE: begin
        if (md_start_ex) begin
          if (md_op_ex == MD_MTHI) begin
            hi_next = src_a_ex;
          end else if (md_op_ex == MD_MTLO) begin
            lo_next = src_a_ex;
          end else if (is_iter_op(md_op_ex)) begin
            // Both modes start from {0, |a|} with |b| as the step operand.
            acc_next     = {{WIDTH{1'b0}}, a_mag};
            operand_next = b_mag;
            is_div_next  = is_div_op(md_op_ex);
            neg_res_next = a_neg ^ b_neg;
            neg_rem_next = a_neg;
            b_zero_next  = (src_b_ex == '0);
            count_next   = CW'(WIDTH - 1);
            state_next   = S_CALC;
          end
        end
      end

      S_CALC: begin
        acc_next = step_acc;
        if (count_reg == '0) begin
          state_next = S_FIX;
        end else begin
          count_next = count_reg - 1'b1;
        end
      end

      S_FIX: begin
        if (is_div_reg) begin
          // With a zero divisor the restoring loop leaves |a| as remainder,
          // and the remainder sign fix turns that back into the dividend.
          lo_next = b_zero_reg ? {WIDTH{1'b1}} : fixed_quot;
          hi_next = fixed_rem;
        end else begin
          lo_next = fixed_prod[WIDTH-1:0];
          hi_next = fixed_prod[2*WIDTH-1:WIDTH];
        end
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      count_reg   <= '0;
      acc_reg     <= '0;
      operand_reg <= '0;
      is_div_reg  <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      b_zero_reg  <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      acc_reg     <= acc_next;
      operand_reg <= operand_next;
      is_div_reg  <= is_div_next;
      neg_res_reg <= neg_res_next;
      neg_rem_reg <= neg_rem_next;
      b_zero_reg  <= b_zero_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
    end
  end

  // Outputs: busy spans CALC through FIX; stall also covers the accept cycle.
  always_comb begin
    hi       = hi_reg;
    lo       = lo_reg;
    md_busy  = (state_reg != S_IDLE);
    md_stall = md_use_id & (md_busy | (md_start_ex & is_iter_op(md_op_ex)));
  end

endmodule
